// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that feeds a UART transmitter one frame at a time
//
// Purpose: accepts host bytes at full clock rate into a DEPTH-entry FIFO and
// hands them to the UART via a tx_data/tx_wr/tx_busy handshake, in write order.
//
// Ports:
//   clk, reset_n          - clock (rising edge), asynchronous active-low reset
//   wr_data, wr_en        - host byte and enqueue strobe
//   flush                 - synchronous clear of FIFO contents and overflow
//   ovf_clr               - clears the sticky overflow flag
//   full, empty, level    - registered occupancy status
//   overflow              - sticky, set when a write is dropped on a full FIFO
//   tx_data, tx_wr        - byte and single-cycle write pulse to the UART
//   tx_busy               - UART frame-in-progress indication
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    input  logic          flush,
    input  logic          ovf_clr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_wr,
    input  logic          tx_busy
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_next;
    logic          wr_accept;
    logic          wr_drop;
    logic          pop;

    // full is the pre-edge registered flag, so a pop in the same cycle never
    // makes room for a write. A write during flush is silently discarded.
    assign wr_accept = wr_en && !full && !flush;
    assign wr_drop   = wr_en &&  full && !flush;

    // empty is registered, so a byte written this cycle cannot be popped
    // until the following cycle.
    assign pop = (state == IDLE) && !empty && !tx_busy;

    always_comb begin
        level_next = level;
        if (flush)
            level_next = '0;
        else if (wr_accept && !pop)
            level_next = level + 1'b1;
        else if (!wr_accept && pop)
            level_next = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            level <= level_next;
            full  <= (level_next == DEPTH_L);
            empty <= (level_next == '0);

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_accept)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end

            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (flush)
                overflow <= 1'b0;
            else if (wr_drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // Drain FSM: one byte in flight at a time. WAIT_BUSY waits for the UART
    // to acknowledge the frame, WAIT_DONE waits for it to finish.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tx_data <= 8'h00;
            tx_wr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_wr <= 1'b0;
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        tx_wr   <= 1'b1;
                        state   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    tx_wr <= 1'b0;
                    if (tx_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    tx_wr <= 1'b0;
                    if (!tx_busy)
                        state <= IDLE;
                end
                default: begin
                    tx_wr <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed scoreboard bench for uart_tx_fifo with a divisor-1 UART model
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       flush;
    logic       ovf_clr;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;

    logic       hold_busy;
    logic       ubusy;
    logic       line;
    logic [8:0] sh;
    logic [3:0] cnt;
    logic [9:0] frame;
    logic       prev_tx_wr;

    int         n_vec = 0;
    int         n_err = 0;
    int         pulses = 0;
    int         p0;
    logic [7:0] exp_q [$];

    assign tx_busy = ubusy | hold_busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART model, divisor 1: start bit, 8 data bits LSB first, stop bit.
    always @(posedge clk) begin
        if (!reset_n) begin
            ubusy <= 1'b0;
            line  <= 1'b1;
            sh    <= '0;
            cnt   <= '0;
        end else if (!ubusy) begin
            if (tx_wr) begin
                ubusy <= 1'b1;
                line  <= 1'b0;
                sh    <= {1'b1, tx_data};
                cnt   <= 4'd9;
            end
        end else if (cnt == 4'd0) begin
            ubusy <= 1'b0;
            line  <= 1'b1;
        end else begin
            line <= sh[0];
            sh   <= {1'b0, sh[8:1]};
            cnt  <= cnt - 4'd1;
        end
    end

    // Line capture: frame[0] is the first bit on the wire.
    always @(negedge clk) begin
        if (ubusy)
            frame <= {line, frame[9:1]};
    end

    // Scoreboard consumer: every tx_wr pulse must match the oldest written byte.
    always @(negedge clk) begin
        if (reset_n && tx_wr) begin
            pulses++;
            check("tx_wr_while_busy", tx_busy, 1'b0);
            check("tx_wr_width", prev_tx_wr, 1'b0);
            check("tx_wr_has_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0)
                check("tx_data_order", tx_data, exp_q.pop_front());
        end
        prev_tx_wr <= tx_wr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit push);
        wr_data = d;
        wr_en   = 1'b1;
        if (push)
            exp_q.push_back(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int quiet = 0;
        for (int i = 0; i < 2000 && quiet < 3; i++) begin
            step();
            if (empty && !tx_busy && !tx_wr)
                quiet++;
            else
                quiet = 0;
        end
        check(tag, quiet >= 3, 1'b1);
    endtask

    initial begin
        reset_n   = 1'b0;
        wr_data   = 8'h00;
        wr_en     = 1'b0;
        flush     = 1'b0;
        ovf_clr   = 1'b0;
        hold_busy = 1'b0;
        repeat (3) step();
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_wr", tx_wr, 0);
        check("rst_tx_data", tx_data, 8'h00);
        reset_n = 1'b1;
        repeat (2) step();

        // Single byte into an idle system
        wr(8'hA5, 1'b1);
        check("single_empty_after_write", empty, 0);
        check("single_level_after_write", level, 1);
        check("single_no_same_cycle_pop", tx_wr, 0);
        step();
        check("single_tx_wr", tx_wr, 1);
        check("single_tx_data", tx_data, 8'hA5);
        check("single_empty_after_pop", empty, 1);
        step();
        check("single_tx_wr_drop", tx_wr, 0);
        check("single_uart_busy", tx_busy, 1);
        wait_drain("single_drain");
        check("single_frame", frame, 10'b1101001010);
        check("single_pulses", pulses, 1);

        // Burst of 16 with the UART held busy, then overflow handling
        hold_busy = 1'b1;
        for (int i = 1; i <= 16; i++)
            wr(8'(i), 1'b1);
        check("burst_full", full, 1);
        check("burst_level", level, 16);
        check("burst_overflow", overflow, 0);
        wr(8'hFF, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, 16);
        ovf_clr = 1'b1;
        wr(8'hFE, 1'b0);
        ovf_clr = 1'b0;
        check("ovf_clr_loses_to_drop", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Write and pop together at level 16
        p0 = pulses;
        hold_busy = 1'b0;
        wr(8'hEE, 1'b0);
        check("simul16_level", level, 15);
        check("simul16_overflow", overflow, 1);
        check("simul16_tx_wr", tx_wr, 1);
        check("simul16_tx_data", tx_data, 8'h01);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        wait_drain("burst_drain");
        check("burst_pulses", pulses - p0, 16);

        // Write and pop together at level 3
        hold_busy = 1'b1;
        wr(8'hAA, 1'b1);
        wr(8'hBB, 1'b1);
        wr(8'hCC, 1'b1);
        check("l3_level", level, 3);
        hold_busy = 1'b0;
        wr(8'hDD, 1'b1);
        check("simul3_level", level, 3);
        check("simul3_tx_wr", tx_wr, 1);
        wait_drain("l3_drain");

        // Flush of a full FIFO with overflow set
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++)
            wr(8'h80 + 8'(i), 1'b1);
        wr(8'h99, 1'b0);
        check("flushA_pre_overflow", overflow, 1);
        flush = 1'b1;
        wr(8'h55, 1'b0);
        flush = 1'b0;
        exp_q.delete();
        check("flushA_level", level, 0);
        check("flushA_empty", empty, 1);
        check("flushA_full", full, 0);
        check("flushA_overflow", overflow, 0);
        p0 = pulses;
        hold_busy = 1'b0;
        repeat (30) step();
        check("flushA_no_tx", pulses, p0);

        // Flush with 8 queued and one byte in flight
        for (int i = 1; i <= 9; i++)
            wr(8'h30 + 8'(i), 1'b1);
        check("flushB_level", level, 8);
        flush = 1'b1;
        wr(8'h66, 1'b0);
        flush = 1'b0;
        exp_q.delete();
        check("flushB_level0", level, 0);
        check("flushB_overflow", overflow, 0);
        p0 = pulses;
        wait_drain("flushB_drain");
        check("flushB_frame", frame, {1'b1, 8'h31, 1'b0});
        repeat (20) step();
        check("flushB_no_more_tx", pulses, p0);

        // Reset mid-frame with 5 queued
        for (int i = 1; i <= 6; i++)
            wr(8'h40 + 8'(i), 1'b1);
        check("midrst_level_before", level, 5);
        check("midrst_busy_before", tx_busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_level", level, 0);
        check("midrst_empty", empty, 1);
        check("midrst_tx_wr", tx_wr, 0);
        check("midrst_tx_data", tx_data, 8'h00);
        exp_q.delete();
        repeat (2) step();
        reset_n = 1'b1;
        p0 = pulses;
        repeat (40) step();
        check("midrst_no_tx", pulses, p0);
        wr(8'h5A, 1'b1);
        wait_drain("midrst_drain");
        check("midrst_new_tx", pulses - p0, 1);
        check("sb_empty_at_end", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer placed directly upstream of the `uart` block's transmitter. It accepts bytes from the host side at full clock rate into a power-of-two FIFO and drains them one at a time into the UART through its `tx_data`/`tx_wr`/`tx_busy` handshake. Bytes reach the line in write order with no gaps beyond the UART's own frame time. Host-side status comprises full/empty/level and a sticky overflow flag.

## Interface
- `DEPTH`, 16 — FIFO entries; power of two, 2..256
- `AW`, 4 — pointer width; must equal log2(DEPTH)
- `clk` input 1 — single clock, rising edge
- `reset_n` input 1 — asynchronous, active-low reset
- `wr_data` input 8 — byte to enqueue
- `wr_en` input 1 — enqueue strobe, one byte per cycle
- `flush` input 1 — synchronous clear of FIFO contents and overflow
- `ovf_clr` input 1 — clears `overflow`
- `full` output 1 — level == DEPTH
- `empty` output 1 — level == 0
- `level` output AW+1 — bytes currently stored (0..DEPTH)
- `overflow` output 1 — sticky; set when a write is dropped
- `tx_data` output 8 — to UART `tx_data`
- `tx_wr` output 1 — to UART `tx_wr`; registered single-cycle pulse
- `tx_busy` input 1 — from UART `tx_busy`

## Operation
- Storage: DEPTH x 8 array, `wr_ptr`/`rd_ptr` AW bits, wrap modulo DEPTH; `level` AW+1 bits, separately counted.
- Write: `wr_en && !full` stores at `wr_ptr`, increments it. `wr_en && full` drops the byte, sets `overflow`. `full` is judged on the pre-edge state; a same-cycle pop does not make room.
- Level update per cycle: +1 on accepted write, −1 on pop, unchanged if both or neither.
- Drain FSM, states IDLE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if `!empty && !tx_busy` → register `tx_data <= mem[rd_ptr]`, `tx_wr <= 1`, `rd_ptr++`, level −1 (pop), go to WAIT_BUSY.
  - WAIT_BUSY: `tx_wr <= 0`. Stay until `tx_busy == 1`, then go to WAIT_DONE.
  - WAIT_DONE: stay until `tx_busy == 0`, then go to IDLE.
- `tx_data` holds its value until the next pop.
- `flush`: pointers and level go to 0; `overflow` clears. A write in the same cycle is discarded without setting `overflow`. FSM state and any byte already handed to the UART are unaffected.
- `ovf_clr` clears `overflow`. A same-cycle drop wins: `overflow` stays 1.

## Timing
- Reset (async assert, sync release), all outputs: `tx_wr`=0, `tx_data`=8'h00, `empty`=1, `full`=0, `level`=0, `overflow`=0. FSM goes to IDLE and pointers go to 0.
- `full`, `empty`, `level` are registered; each reflects the write/pop of the previous edge.
- Write→`tx_wr` latency, FIFO empty and UART idle: write at edge E, `empty` falls after E, `tx_wr` high after E+1 for exactly one cycle.
- UART samples `tx_wr` at E+2 and raises `tx_busy` after E+2. The FSM leaves WAIT_BUSY on E+3.
- Next `tx_wr` is no earlier than two cycles after `tx_busy` falls.
- Never more than one byte in flight. `tx_wr` is never asserted while `tx_busy`=1 or in a non-IDLE state.
- Write into an empty FIFO in the same cycle the FSM evaluates IDLE: no pop that cycle, because `empty` is registered.

## Test plan
- Reset mid-frame: assert `reset_n`=0 with 5 bytes queued and the FSM in WAIT_DONE → next cycle `level`=0, `empty`=1, `tx_wr`=0. After release, no `tx_wr` until a new write.
- Single byte: write 8'hA5 into an idle system with a UART model, divisor 1 → one `tx_wr` pulse two cycles after the write with `tx_data`=8'hA5. The line shows 0,1,0,1,0,0,1,0,1,1 LSB-first frame; `empty`=1 after the pop.
- Burst order: write 8'h01..8'h10 back-to-back, DEPTH=16 → `full`=1 after the 16th write, `overflow`=0. The UART emits 01..10 in order with exactly 16 `tx_wr` pulses.
- Overflow: with the FIFO full and `tx_busy` held 1, write 8'hFF → byte dropped, `overflow`=1, `level` stays 16. Asserting `ovf_clr` clears the flag on the next cycle.
- Simultaneous events: at `level`=16, write and pop in the same cycle → write dropped, `overflow`=1, `level`=15. At `level`=3, write and pop → `level` stays 3.
- Flush: with 8 queued and a byte in flight, assert `flush` with `wr_en` → `level`=0, `overflow`=0. The in-flight frame completes and no further `tx_wr` follows.
